// File: rtl/cnn_core_stream.sv
// CNN output-channel engine: serially loaded weight/bias bank, 3-cycle multiply/add-tree/bias+saturate pipeline,
// valid/ready stalls freeze every stage. Optional ReLU before saturation via CNN_CORE_STREAM_RELU_EN.
module cnn_core_stream #(
  parameter int CO     = 16,
  parameter int CI     = 3,
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int W_BW   = 8,
  parameter int B_BW   = 16,
  parameter int O_F_BW = 16,
  localparam int CFG_BW = (W_BW > B_BW) ? W_BW : B_BW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_soft_reset,
  input  logic                       i_cfg_start,
  input  logic                       i_cfg_valid,
  input  logic [CFG_BW-1:0]          i_cfg_data,
  output logic                       o_cfg_busy,
  output logic                       o_cfg_done,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [CI*KY*KX*I_F_BW-1:0] i_in_fmap,
  output logic                       o_ot_valid,
  input  logic                       i_ot_ready,
  output logic [CO*O_F_BW-1:0]       o_ot_fmap
);

  localparam int NE     = CI*KY*KX;
  localparam int NW     = CO*NE;
  localparam int P_BW   = W_BW + I_F_BW;
  localparam int ACC_BW = I_F_BW + W_BW + $clog2(CI*KX*KY);
  localparam int SUM_BW = ((ACC_BW > B_BW) ? ACC_BW : B_BW) + 1;
  localparam int CNT_BW = $clog2(NW + CO);
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(NW + CO - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                    r_state, w_state_nx;
  logic [CNT_BW-1:0]         r_cnt;
  logic                      r_done;
  logic signed [W_BW-1:0]    r_w [NW];
  logic signed [B_BW-1:0]    r_b [CO];
  logic                      r_v1, r_v2, r_v3;
  logic signed [P_BW-1:0]    r_p [NW];
  logic signed [ACC_BW-1:0]  r_s [CO];
  logic [CO*O_F_BW-1:0]      r_o;

  logic                      w_stall, w_inflight, w_start_ok, w_wr, w_last, w_accept;
  logic signed [ACC_BW-1:0]  w_sum [CO];
  logic [CO*O_F_BW-1:0]      w_res;

  assign w_stall    = r_v3 & ~i_ot_ready;
  assign w_inflight = r_v1 | r_v2 | r_v3;
  // A start in RUN is only honoured on an empty pipe so weights never change under a live window.
  assign w_start_ok = i_cfg_start & ((r_state != RUN) | ~w_inflight);
  assign w_wr       = (r_state == LOAD) & i_cfg_valid & ~i_cfg_start & ~i_soft_reset;
  assign w_last     = w_wr & (r_cnt == LAST);
  assign w_accept   = i_in_valid & o_in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (i_soft_reset) begin
      if (r_state == LOAD) w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_cfg_start) w_state_nx = LOAD;
        LOAD:    if (w_last) w_state_nx = RUN;
        RUN:     if (w_start_ok) w_state_nx = LOAD;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    o_cfg_busy = (r_state == LOAD);
    o_cfg_done = r_done;
    o_in_ready = (r_state == RUN) & ~w_stall;
    o_ot_valid = r_v3;
    o_ot_fmap  = r_o;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_soft_reset) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_start_ok)  r_cnt <= '0;
      else if (w_wr)   r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Entries 0..NW-1 are weights in (co,ci,ky,kx) order, NW..NW+CO-1 are biases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NW; i++) r_w[i] <= '0;
      for (int i = 0; i < CO; i++) r_b[i] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NW; i++)
        if (r_cnt == CNT_BW'(i)) r_w[i] <= i_cfg_data[W_BW-1:0];
      for (int i = 0; i < CO; i++)
        if (r_cnt == CNT_BW'(NW + i)) r_b[i] <= i_cfg_data[B_BW-1:0];
    end
  end

  always_comb begin
    for (int c = 0; c < CO; c++) begin
      w_sum[c] = '0;
      for (int e = 0; e < NE; e++) w_sum[c] = w_sum[c] + ACC_BW'(r_p[c*NE + e]);
    end
  end

  function automatic logic [O_F_BW-1:0] sat(input logic signed [SUM_BW-1:0] s);
    logic signed [SUM_BW-1:0] v;
    v = s;
`ifdef CNN_CORE_STREAM_RELU_EN
    if (v[SUM_BW-1]) v = '0;
`else
`endif
    // In range when every bit above the output sign bit matches it.
    if ((&v[SUM_BW-1:O_F_BW-1]) || ~(|v[SUM_BW-1:O_F_BW-1])) sat = v[O_F_BW-1:0];
    else if (v[SUM_BW-1])                                      sat = {1'b1, {(O_F_BW-1){1'b0}}};
    else                                                       sat = {1'b0, {(O_F_BW-1){1'b1}}};
  endfunction

  always_comb begin
    w_res = '0;
    for (int c = 0; c < CO; c++)
      w_res[c*O_F_BW +: O_F_BW] = sat(SUM_BW'(r_s[c]) + SUM_BW'(r_b[c]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      for (int i = 0; i < NW; i++) r_p[i] <= '0;
      for (int c = 0; c < CO; c++) r_s[c] <= '0;
      r_o  <= '0;
    end else if (i_soft_reset) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (!w_stall) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      for (int c = 0; c < CO; c++)
        for (int e = 0; e < NE; e++)
          r_p[c*NE + e] <= r_w[c*NE + e] * $signed(i_in_fmap[e*I_F_BW +: I_F_BW]);
      for (int c = 0; c < CO; c++) r_s[c] <= w_sum[c];
      r_o  <= w_res;
    end
  end

endmodule

// File: tb/tb_cnn_core_stream.sv
// Bench for cnn_core_stream: table-driven bank/window vectors, scoreboarded streaming with stall,
// config-start gating, mid-load reset and soft reset corner cases.
module tb_cnn_core_stream;

  localparam int CO = 16, CI = 3, KX = 3, KY = 3, IFB = 8, OFB = 16;
  localparam int NE = CI*KY*KX;
  localparam int NW = CO*NE;
`ifdef CNN_CORE_STREAM_RELU_EN
  localparam int NEG_SAT = 0;
  localparam int NEG_SMALL = 0;
`else
  localparam int NEG_SAT = -32768;
  localparam int NEG_SMALL = -270;
`endif

  logic clk = 1'b0;
  logic reset, i_soft_reset, i_cfg_start, i_cfg_valid;
  logic [15:0] i_cfg_data;
  logic o_cfg_busy, o_cfg_done;
  logic i_in_valid, o_in_ready;
  logic [NE*IFB-1:0] i_in_fmap;
  logic o_ot_valid, i_ot_ready;
  logic [CO*OFB-1:0] o_ot_fmap;

  cnn_core_stream dut (
    .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset),
    .i_cfg_start(i_cfg_start), .i_cfg_valid(i_cfg_valid), .i_cfg_data(i_cfg_data),
    .o_cfg_busy(o_cfg_busy), .o_cfg_done(o_cfg_done),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_fmap(i_in_fmap),
    .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready), .o_ot_fmap(o_ot_fmap)
  );

  always #5 clk = ~clk;

  typedef struct { int wv; int xv; int bstep; int ebase; int estep; } vec_t;

  int n_chk = 0, n_err = 0, n_rcv = 0;
  int tb_w [NW];
  int tb_b [CO];
  int tb_x [NE];
  int win_x [6][NE];
  logic [CO*OFB-1:0] win_e [6];
  logic [CO*OFB-1:0] sb [$];
  logic [CO*OFB-1:0] mon_exp, expv, held;
  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [CO*OFB-1:0] got, input logic [CO*OFB-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s timed out", nm);
  endtask

  always @(negedge clk) begin
    if (!reset && o_ot_valid && i_ot_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_unexpected got=%h want=no output", o_ot_fmap);
      end else begin
        mon_exp = sb.pop_front();
        chk("sb_data", o_ot_fmap, mon_exp);
        n_rcv++;
      end
    end
  end

  function automatic logic [CO*OFB-1:0] model();
    logic [CO*OFB-1:0] r;
    int acc;
    r = '0;
    for (int c = 0; c < CO; c++) begin
      acc = tb_b[c];
      for (int e = 0; e < NE; e++) acc += tb_w[c*NE + e] * tb_x[e];
`ifdef CNN_CORE_STREAM_RELU_EN
      if (acc < 0) acc = 0;
`endif
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      r[c*OFB +: OFB] = 16'(acc);
    end
    return r;
  endfunction

  task automatic drive_win();
    for (int e = 0; e < NE; e++) i_in_fmap[e*IFB +: IFB] = IFB'(tb_x[e]);
  endtask

  task automatic rand_x();
    for (int e = 0; e < NE; e++) tb_x[e] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic rand_bank();
    for (int k = 0; k < NW; k++) tb_w[k] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < CO; c++) tb_b[c] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin tick(); t++; end
    if (sb.size() != 0) fail_to("drain");
  endtask

  task automatic load_bank();
    i_cfg_start = 1'b1;
    tick();
    i_cfg_start = 1'b0;
    chk("load_busy", o_cfg_busy, 1);
    chk("load_inrdy", o_in_ready, 0);
    for (int k = 0; k < NW + CO; k++) begin
      i_cfg_valid = 1'b1;
      i_cfg_data  = (k < NW) ? 16'(tb_w[k]) : 16'(tb_b[k - NW]);
      tick();
      if (k == NW + CO - 2) chk("done_early", o_cfg_done, 0);
    end
    i_cfg_valid = 1'b0;
    chk("done_pulse", o_cfg_done, 1);
    chk("busy_end", o_cfg_busy, 0);
    tick();
    chk("done_clear", o_cfg_done, 0);
  endtask

  task automatic send_one(input logic [CO*OFB-1:0] exp, input string nm);
    int t, lat;
    drive_win();
    i_in_valid = 1'b1;
    t = 0;
    while (!o_in_ready && t < 50) begin tick(); t++; end
    if (!o_in_ready) begin
      fail_to({nm, "_accept"});
      i_in_valid = 1'b0;
      return;
    end
    sb.push_back(exp);
    tick();
    i_in_valid = 1'b0;
    lat = 1;
    while (!o_ot_valid && lat < 50) begin tick(); lat++; end
    chk({nm, "_lat"}, lat, 3);
    wait_drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, base, seen;
    vt[0] = '{1, 2, 0, 54, 0};
    vt[1] = '{127, 127, 0, 32767, 0};
    vt[2] = '{-128, 127, 0, NEG_SAT, 0};
    vt[3] = '{0, 5, 10, 0, 10};
    vt[4] = '{2, -5, 0, NEG_SMALL, 0};
    vt[5] = '{-1, -128, 1000, 3456, 1000};

    reset = 1'b1; i_soft_reset = 1'b0; i_cfg_start = 1'b0; i_cfg_valid = 1'b0;
    i_cfg_data = '0; i_in_valid = 1'b0; i_in_fmap = '0; i_ot_ready = 1'b1;
    #1;
    chk("rst_vld", o_ot_valid, 0);
    chk("rst_fmap", o_ot_fmap, 0);
    chk("rst_busy", o_cfg_busy, 0);
    chk("rst_done", o_cfg_done, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_inrdy", o_in_ready, 0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NW; k++) tb_w[k] = vt[i].wv;
      for (int c = 0; c < CO; c++) tb_b[c] = c * vt[i].bstep;
      for (int e = 0; e < NE; e++) tb_x[e] = vt[i].xv;
      load_bank();
      for (int c = 0; c < CO; c++) expv[c*OFB +: OFB] = 16'(vt[i].ebase + c * vt[i].estep);
      send_one(expv, $sformatf("vec%0d", i));
    end

    // Six back-to-back windows with the sink stalled for cycles 4..7.
    rand_bank();
    load_bank();
    for (int w = 0; w < 6; w++) begin
      rand_x();
      for (int e = 0; e < NE; e++) win_x[w][e] = tb_x[e];
      win_e[w] = model();
    end
    base = n_rcv;
    sent = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (sent < 6) begin
        for (int e = 0; e < NE; e++) tb_x[e] = win_x[sent][e];
        drive_win();
        i_in_valid = 1'b1;
      end else begin
        i_in_valid = 1'b0;
      end
      i_ot_ready = !(cyc >= 4 && cyc < 8);
      #1;
      if (cyc >= 4 && cyc < 8) begin
        chk("stall_inrdy", o_in_ready, 0);
        chk("stall_vld", o_ot_valid, 1);
        if (cyc == 4) held = o_ot_fmap;
        else chk("stall_hold", o_ot_fmap, held);
      end
      if (i_in_valid && o_in_ready) begin
        sb.push_back(win_e[sent]);
        sent++;
      end
      tick();
    end
    i_in_valid = 1'b0;
    i_ot_ready = 1'b1;
    wait_drain();
    chk("stream_count", n_rcv - base, 6);

    // Start with two windows in flight is ignored; after drain it is taken.
    for (int w = 0; w < 2; w++) begin
      for (int e = 0; e < NE; e++) tb_x[e] = win_x[w][e];
      drive_win();
      i_in_valid = 1'b1;
      chk("inflight_rdy", o_in_ready, 1);
      sb.push_back(win_e[w]);
      tick();
    end
    i_in_valid = 1'b0;
    i_cfg_start = 1'b1;
    tick();
    i_cfg_start = 1'b0;
    chk("start_ign_busy", o_cfg_busy, 0);
    chk("start_ign_rdy", o_in_ready, 1);
    wait_drain();
    load_bank();

    // Hard reset after 50 config words.
    i_cfg_start = 1'b1;
    tick();
    i_cfg_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      i_cfg_valid = 1'b1;
      i_cfg_data = 16'h0055;
      tick();
    end
    i_cfg_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", o_cfg_busy, 0);
    chk("mid_rst_vld", o_ot_valid, 0);
    chk("mid_rst_fmap", o_ot_fmap, 0);
    chk("mid_rst_rdy", o_in_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    i_cfg_valid = 1'b1;
    tick(); tick(); tick();
    i_cfg_valid = 1'b0;
    chk("idle_cfg_ign", o_cfg_busy, 0);
    rand_bank();
    load_bank();
    rand_x();
    send_one(model(), "post_rst");

    // Soft reset with two windows in flight; bank must survive.
    for (int w = 0; w < 2; w++) begin
      rand_x();
      drive_win();
      i_in_valid = 1'b1;
      tick();
    end
    i_in_valid = 1'b0;
    i_soft_reset = 1'b1;
    tick();
    i_soft_reset = 1'b0;
    seen = 0;
    for (int t = 0; t < 4; t++) begin
      if (o_ot_valid) seen++;
      tick();
    end
    chk("soft_flush", seen, 0);
    chk("soft_run_rdy", o_in_ready, 1);
    i_cfg_valid = 1'b1;
    i_cfg_data = 16'h007f;
    tick(); tick(); tick();
    i_cfg_valid = 1'b0;
    rand_x();
    send_one(model(), "soft_keep");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cnn_core_stream.md
Name: cnn_core_stream

Overview:
- Parametrised successor CNN output-channel engine.
- Holds a runtime-loadable bank of CO*CI*KY*KX weights and CO biases, loaded serially through a config port.
- Computes CO signed dot-products plus bias per accepted input window, through a 3-stage pipeline with valid/ready backpressure and output saturation.
- Sits between the window line-buffer and the pooling/writeback stage.

Parameters:
- CO, 16, output channels
- CI, 3, input channels
- KX, 3, kernel width
- KY, 3, kernel height
- I_F_BW, 8, signed input feature width
- W_BW, 8, signed weight width
- B_BW, 16, signed bias width
- O_F_BW, 16, signed output width (saturated)
- ACC_BW, I_F_BW+W_BW+$clog2(CI*KX*KY), derived accumulator width (localparam)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_soft_reset  in  1  synchronous pipeline/FSM clear
- i_cfg_start  in  1  begin weight/bias load
- i_cfg_valid  in  1  config word strobe
- i_cfg_data  in  max(W_BW,B_BW)  config word; low W_BW bits used for weights
- o_cfg_busy  out  1  FSM in LOAD
- o_cfg_done  out  1  1-cycle pulse on last config word
- i_in_valid  in  1  input window valid
- o_in_ready  out  1  input window accepted when valid&ready
- i_in_fmap  in  CI*KY*KX*I_F_BW  window; element e at [e*I_F_BW +: I_F_BW]
- o_ot_valid  out  1  result valid
- i_ot_ready  in  1  downstream ready
- o_ot_fmap  out  CO*O_F_BW  channel c at [c*O_F_BW +: O_F_BW]

Behaviour:
- Clocking: single clock clk. reset is asynchronous and active-high. On reset: FSM=IDLE, all weights/biases=0, config counter=0, all stage valids=0, o_ot_fmap=0, o_ot_valid=0, o_in_ready=0, o_cfg_busy=0, o_cfg_done=0.
- FSM states IDLE, LOAD, RUN:
  - IDLE: i_cfg_start -> LOAD, counter=0.
  - LOAD: each i_cfg_valid writes entry[counter] and counter++.
    - Entries 0..NW-1 (NW=CO*CI*KY*KX) are weights. Weight index = ((co*CI+ci)*KY+ky)*KX+kx.
    - Entries NW..NW+CO-1 are biases 0..CO-1.
    - Write at counter=NW+CO-1 -> RUN, with o_cfg_done pulsing the following cycle.
    - i_cfg_start in LOAD restarts the counter at 0.
  - RUN: i_cfg_start is accepted only when all pipeline stage valids are 0; it then goes -> LOAD. Otherwise it is ignored (no queuing).
- i_cfg_valid outside LOAD is ignored.
- o_in_ready = (state==RUN) & !stall, where stall = o_ot_valid & !i_ot_ready.
- Pipeline: all stages advance only when !stall.
  - S1: registers CO*CI*KY*KX signed products W_BW+I_F_BW wide.
  - S2: registers per-channel adder-tree sums, sign-extended to ACC_BW.
  - S3: registers sum + sign-extended bias, then optional activation, then saturation to O_F_BW. Results above 2^(O_F_BW-1)-1 clamp to max; below -2^(O_F_BW-1) clamp to min.
- Latency: result appears on o_ot_valid 3 cycles after acceptance, absent stall. Throughput is 1 window/cycle.
- Backpressure: o_ot_fmap and o_ot_valid hold stable while stalled. No data is lost or duplicated. Bubbles are not compressed.
- Config is frozen while any data is in flight, so weights never change under a live window.
- i_soft_reset:
  - Clears stage valids, o_ot_valid, o_cfg_done and counter.
  - FSM -> IDLE when in LOAD, else stays in RUN/IDLE.
  - Weight/bias bank is retained.
  - Takes priority over every same-cycle event.
- reset mid-LOAD: bank zeroed, FSM IDLE; a fresh load is required.

Optional Feature:
- Macro CNN_CORE_STREAM_RELU_EN.
- Defined: S3 applies ReLU (negative -> 0) before saturation. Outputs are never negative.
- Undefined: no activation; signed saturated value passes through.

Test Plan:
- Load all weights=1, biases=0; stream 1 window with every element=2 -> o_ot_valid 3 cycles after accept, every channel=54.
- Weights=127, inputs=127, bias=0 -> every channel=32767 (435483 saturated). Weights=-128, inputs=127 -> -32768 without RELU_EN, 0 with RELU_EN.
- Bias c=c*10, weights=0 -> channel c = c*10. Verifies bias ordering and o_cfg_done pulse after word NW+CO-1.
- Stream 6 back-to-back windows; hold i_ot_ready=0 for 4 cycles mid-stream -> o_in_ready drops while stalled, outputs held stable, all 6 results delivered in order.
- Assert i_cfg_start in RUN with 2 windows in flight -> ignored. Reassert after drain -> LOAD, o_cfg_busy=1, o_in_ready=0.
- Assert reset after 50 config words -> IDLE, outputs 0, bank 0. Assert soft reset in RUN with data in flight -> valids cleared, bank kept, next window computes with old weights.
